// File: rtl/lc_event_pkg.sv
// Shared types and helpers for the local-coincidence event builder.
package lc_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GATE,
    ST_PUSH,
    ST_HOLDOFF
  } state_t;

  localparam int NHIT_W = 8;

  // Packed record layout is {mask, ts, nhit}, mask in the MSBs.
  function automatic int rec_width(input int n_ch, input int ts_w);
    return n_ch + ts_w + NHIT_W;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lc_event_builder_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head word is visible whenever empty is low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/lc_event_builder.sv
// Collapses each local-coincidence burst into one {mask, first-hit ts, nhit} record,
// with rate-limiting holdoff and a drop counter for records that find the FIFO full.
module lc_event_builder
  import lc_event_pkg::*;
#(
  parameter int N_CHANNELS = 24,
  parameter int TS_WIDTH   = 48,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [N_CHANNELS-1:0]         lc_in,
  input  logic [TS_WIDTH-1:0]           timestamp,
  input  logic [15:0]                   gate_len,
  input  logic [15:0]                   holdoff_len,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [N_CHANNELS-1:0]         evt_mask,
  output logic [TS_WIDTH-1:0]           evt_ts,
  output logic [NHIT_W-1:0]             evt_nhit,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   drop_cnt
);

  localparam int REC_W = rec_width(N_CHANNELS, TS_WIDTH);

  typedef struct packed {
    logic [N_CHANNELS-1:0] mask;
    logic [TS_WIDTH-1:0]   ts;
    logic [NHIT_W-1:0]     nhit;
  } rec_t;

  state_t                state;
  logic [N_CHANNELS-1:0] mask;
  logic [TS_WIDTH-1:0]   ts;
  logic [15:0]           gate_cnt;
  logic [15:0]           hold_cnt;
  logic [15:0]           gate_load;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_wr;
  rec_t                  wr_rec;
  rec_t                  rd_rec;
  logic [REC_W-1:0]      wr_data;
  logic [REC_W-1:0]      rd_data;

  function automatic logic [NHIT_W-1:0] popcount(input logic [N_CHANNELS-1:0] v);
    logic [NHIT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_CHANNELS; i++) c = c + NHIT_W'(v[i]);
    return c;
  endfunction

  // A zero gate length behaves as a one-cycle window.
  assign gate_load = (gate_len == 16'd0) ? 16'd0 : gate_len - 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mask     <= '0;
      ts       <= '0;
      gate_cnt <= '0;
      hold_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && |lc_in) begin
            mask     <= lc_in;
            ts       <= timestamp;
            gate_cnt <= gate_load;
            state    <= (gate_load == 16'd0) ? ST_PUSH : ST_GATE;
          end
        end
        ST_GATE: begin
          mask     <= mask | lc_in;
          gate_cnt <= gate_cnt - 16'd1;
          if (gate_cnt == 16'd1) state <= ST_PUSH;
        end
        ST_PUSH: begin
          // Fullness comes from the registered count, so a same-cycle pop cannot rescue the event.
          if (fifo_full) drop_cnt <= sat_inc16(drop_cnt);
          hold_cnt <= holdoff_len;
          state    <= (holdoff_len != 16'd0) ? ST_HOLDOFF : ST_IDLE;
        end
        ST_HOLDOFF: begin
          hold_cnt <= hold_cnt - 16'd1;
          if (hold_cnt == 16'd1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fifo_wr     = (state == ST_PUSH) && !fifo_full;
  assign wr_rec.mask = mask;
  assign wr_rec.ts   = ts;
  assign wr_rec.nhit = popcount(mask);
  assign wr_data     = wr_rec;

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (wr_data),
    .rd_en   (evt_ready),
    .rd_data (rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rd_rec    = rd_data;
  assign evt_valid = !fifo_empty;
  assign evt_mask  = rd_rec.mask;
  assign evt_ts    = rd_rec.ts;
  assign evt_nhit  = rd_rec.nhit;

endmodule

// File: tb/tb_lc_event_builder.sv
// Directed bench for lc_event_builder with a record scoreboard checked on every pop.
module tb_lc_event_builder;

  localparam int N     = 24;
  localparam int TSW   = 48;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b0;
  logic [N-1:0]    lc_in = '0;
  logic [TSW-1:0]  timestamp = '0;
  logic [15:0]     gate_len = 16'd1;
  logic [15:0]     holdoff_len = 16'd0;
  logic            evt_ready = 1'b0;
  logic            evt_valid;
  logic [N-1:0]    evt_mask;
  logic [TSW-1:0]  evt_ts;
  logic [7:0]      evt_nhit;
  logic [4:0]      fifo_count;
  logic [15:0]     drop_cnt;

  typedef struct packed {
    logic [N-1:0]   mask;
    logic [TSW-1:0] ts;
    logic [7:0]     nhit;
  } rec_t;

  rec_t           exp_q[$];
  rec_t           e;
  int             checks = 0;
  int             errors = 0;
  logic [TSW-1:0] last_ts = '0;
  bit             have_last = 1'b0;
  logic [TSW-1:0] t0;

  lc_event_builder #(
    .N_CHANNELS (N),
    .TS_WIDTH   (TSW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .lc_in       (lc_in),
    .timestamp   (timestamp),
    .gate_len    (gate_len),
    .holdoff_len (holdoff_len),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_mask    (evt_mask),
    .evt_ts      (evt_ts),
    .evt_nhit    (evt_nhit),
    .fifo_count  (fifo_count),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) timestamp <= timestamp + 1'b1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rec(input logic [N-1:0] m, input logic [TSW-1:0] t);
    rec_t r;
    r.mask = m;
    r.ts   = t;
    r.nhit = 8'($countones(m));
    exp_q.push_back(r);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    evt_ready = 1'b1;
    while (evt_valid === 1'b1 && n < 64) begin
      tick();
      n++;
    end
    evt_ready = 1'b0;
    chk({tag, "_drained"}, evt_valid, 1'b0);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // Scoreboard: every accepted head record must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=record mask %0h expected=no record", evt_mask);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rec_mask", evt_mask, e.mask);
        chk("rec_ts", evt_ts, e.ts);
        chk("rec_nhit", evt_nhit, e.nhit);
        if (have_last) chk("ts_order", evt_ts > last_ts, 1'b1);
        last_ts   = evt_ts;
        have_last = 1'b1;
      end
    end
  end

  initial begin
    int n;
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_count", fifo_count, 0);
    chk("rst_drop", drop_cnt, 0);
    rst    = 1'b0;
    enable = 1'b1;

    // Single pulse at timestamp 1000, gate 4
    gate_len = 16'd4;
    holdoff_len = 16'd0;
    n = 0;
    while (timestamp != 48'd1000 && n < 2000) begin
      tick();
      n++;
    end
    lc_in = 24'h000005;
    expect_rec(lc_in, timestamp);
    tick();
    lc_in = '0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("pulse_valid_T%0d", k), evt_valid, 1'b0);
      tick();
    end
    chk("pulse_valid_T5", evt_valid, 1'b1);
    chk("pulse_count", fifo_count, 1);
    chk("pulse_head_mask", evt_mask, 24'h000005);
    chk("pulse_head_ts", evt_ts, 48'd1000);
    chk("pulse_head_nhit", evt_nhit, 8'd2);
    drain("pulse");

    // Accumulation over gate 8; hit in PUSH cycle is ignored
    gate_len = 16'd8;
    repeat (2) tick();
    lc_in = 24'h000001;
    expect_rec(24'h800081, timestamp);
    tick();
    lc_in = 24'h000080;
    tick();
    lc_in = 24'h800000;
    tick();
    lc_in = '0;
    repeat (5) tick();
    lc_in = 24'h001000;
    tick();
    lc_in = '0;
    repeat (3) tick();
    chk("accum_count", fifo_count, 1);
    drain("accum");

    // Holdoff: continuous hit, gate 1, holdoff 10 -> period 12
    gate_len    = 16'd1;
    holdoff_len = 16'd10;
    evt_ready   = 1'b1;
    t0 = timestamp;
    for (int k = 0; k < 4; k++) expect_rec(24'h000001, t0 + TSW'(12 * k));
    lc_in = 24'h000001;
    repeat (37) tick();
    lc_in = '0;
    repeat (15) tick();
    drain("holdoff");

    // Backpressure and overflow: 20 triggers into a 16-deep FIFO
    holdoff_len = 16'd0;
    evt_ready   = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      lc_in = N'(1) << (i % N);
      if (i < DEPTH) expect_rec(lc_in, timestamp);
      tick();
      lc_in = '0;
      repeat (3) tick();
    end
    chk("ovf_count", fifo_count, 16);
    chk("ovf_drop", drop_cnt, 4);
    chk("ovf_valid", evt_valid, 1'b1);

    // Full FIFO with a pop in the PUSH cycle still drops
    lc_in = 24'h00ABCD;
    tick();
    lc_in = '0;
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("fullpop_drop", drop_cnt, 5);
    chk("fullpop_count", fifo_count, 15);
    drain("ovf");

    // Disabled: hits in IDLE must not start an event
    enable = 1'b0;
    lc_in  = 24'h000001;
    repeat (3) tick();
    lc_in  = '0;
    enable = 1'b1;
    repeat (3) tick();
    chk("disable_count", fifo_count, 0);

    // Reset two cycles into an 8-cycle gate discards the partial event
    gate_len = 16'd8;
    lc_in = 24'h000003;
    tick();
    lc_in = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", evt_valid, 1'b0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_drop", drop_cnt, 0);
    repeat (10) tick();
    chk("midrst_norec", fifo_count, 0);

    // gate_len 0 behaves as 1
    gate_len = 16'd0;
    lc_in = 24'h000010;
    expect_rec(lc_in, timestamp);
    tick();
    lc_in = '0;
    chk("g0_valid_T1", evt_valid, 1'b0);
    tick();
    chk("g0_valid_T2", evt_valid, 1'b1);
    drain("g0");

    chk("final_sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc_event_builder.md
# lc_event_builder

Downstream of the local-coincidence stage: consumes the per-channel `local_coinc` vector and turns each coincidence burst into one event record.
- Record contents: OR-accumulated channel mask, timestamp of the first hit, and hit count.
- Records are buffered in a small FIFO and drained over a valid/ready handshake toward readout.
- A programmable holdoff after each event limits the event rate; events arriving when the FIFO is full are counted and dropped.

## Interface
- `N_CHANNELS`, 24, width of coincidence input and event mask (1..255)
- `TS_WIDTH`, 48, timestamp width
- `FIFO_DEPTH`, 16, event FIFO depth (power of two)
- `clk`  in  1  sole clock
- `rst`  in  1  synchronous reset, active-high
- `enable`  in  1  permits new events; sampled only in IDLE
- `lc_in`  in  N_CHANNELS  local-coincidence vector from upstream
- `timestamp`  in  TS_WIDTH  free-running system time
- `gate_len`  in  16  accumulation window in cycles; 0 treated as 1
- `holdoff_len`  in  16  dead time after each event, in cycles
- `evt_valid`  out  1  FIFO head valid
- `evt_ready`  in  1  consumer accepts the head
- `evt_mask`  out  N_CHANNELS  head record: channel mask
- `evt_ts`  out  TS_WIDTH  head record: first-hit timestamp
- `evt_nhit`  out  8  head record: popcount of mask
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupancy
- `drop_cnt`  out  16  dropped-event counter, saturating

## Operation
- FSM states: IDLE, GATE, PUSH, HOLDOFF.
- IDLE → GATE:
  - Condition: `enable` && `|lc_in`.
  - Actions: `mask` ← `lc_in`, `ts` ← `timestamp`, gate counter ← max(`gate_len`,1)−1.
  - If the loaded counter is 0, go to PUSH instead of GATE.
- GATE:
  - Each cycle: `mask` ← `mask | lc_in`; counter decrements.
  - Counter reaching 0 (after that cycle's OR) → PUSH.
- PUSH (one cycle):
  - Compute `nhit` = popcount(`mask`).
  - If FIFO not full: write {`mask`, `ts`, `nhit`}.
  - If FIFO full: no write; `drop_cnt` increments, saturating at 0xFFFF.
  - Fullness is evaluated on the registered count before any same-cycle pop, so a full FIFO drops even with a simultaneous read.
  - Next state: HOLDOFF if `holdoff_len` ≠ 0, else IDLE.
- HOLDOFF: counts `holdoff_len` cycles, then → IDLE.
- `lc_in` is ignored in PUSH and HOLDOFF; those hits are lost by design and are not counted.
- `enable` deasserted mid-event: the current event completes normally.
- FIFO:
  - First-word-fall-through.
  - Pop on `evt_valid && evt_ready`.
  - Output fields are undefined when `evt_valid`=0.
- `gate_len` and `holdoff_len` are sampled when the respective counter loads; changes mid-event take effect on the next event.

## Timing
- Trigger sampled in IDLE at cycle T.
- Accumulation covers cycles T … T+G−1, where G = max(`gate_len`,1).
- PUSH at T+G.
- `evt_valid` rises at T+G+1 if the FIFO was empty.
- HOLDOFF covers T+G+1 … T+G+H, where H = `holdoff_len`.
- Earliest next trigger sample: T+G+H+1.
- Sustained event period is therefore G+H+1 cycles.
- `fifo_count` updates the cycle after a push or pop. A simultaneous push and pop leaves the count unchanged.
- Reset values: FSM IDLE, FIFO empty, `evt_valid`=0, `fifo_count`=0, `drop_cnt`=0, internal mask and timestamp registers 0.
- Reset asserted mid-event discards the partial event. The first trigger after reset is sampled no earlier than the first cycle with `rst`=0.
- No combinational path from `lc_in` or `evt_ready` to any output except `evt_valid` and the record fields via the FIFO read pointer.

## Structure
- Package `lc_event_pkg`:
  - FSM state enum.
  - `NHIT_W`=8.
  - Record struct/width helper {mask, ts, nhit} parameterised by N_CHANNELS and TS_WIDTH.
  - Saturating-increment function for `drop_cnt`.
- Sub-module `sync_fifo`:
  - Single-clock, FWFT, parameter WIDTH/DEPTH.
  - Outputs count, full, empty.
  - Synchronous active-high reset.
- Top: FSM, gate and holdoff counters, accumulators, popcount, drop counter.

## Test plan
- Single pulse: `lc_in`=0x000005 for 1 cycle at `timestamp`=1000, `gate_len`=4, `holdoff_len`=0 → one record {mask 0x000005, ts 1000, nhit 2}, `evt_valid` at T+5.
- Accumulation: bits 0, 7, 23 on successive cycles inside `gate_len`=8; bit 12 at T+8 → mask 0x800081, nhit 3. Bit 12 opens a second event only if still asserted in IDLE.
- Holdoff: `gate_len`=1, `holdoff_len`=10, `lc_in` held at 0x1 continuously, `evt_ready`=1 → records with ts spaced exactly 12 cycles.
- Backpressure and overflow: `evt_ready`=0, 20 separated triggers, FIFO_DEPTH=16 → `fifo_count`=16, `drop_cnt`=4. Then drain: 16 records in order with increasing ts.
- Full-with-pop corner: FIFO full, PUSH coincides with a pop → event dropped, `drop_cnt`+1, `fifo_count`=15.
- Reset mid-GATE: `rst` for 1 cycle at T+2 of an 8-cycle gate → no record written, all outputs at reset values. A new trigger afterwards produces a correct record. `gate_len`=0 behaves as 1.
